imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the fetch stage's instruction read.
- Receives a boot image over a 16-bit valid/ready stream, assembles pairs of halfwords into 32-bit instructions, and writes them into the instruction memory write port.
- Holds the processor in `cpu_hold` until the image is fully written, then releases it.

Parameters:
- ADDR_W, 12, instruction-memory word-address width; DEPTH = 2**ADDR_W.
- BASE_ADDR, 0, word address at which the first instruction is written.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a load; ignored while busy=1.
- s_valid  in  1  host word valid.
- s_ready  out  1  loader can accept a word this cycle.
- s_data  in  16  host word: length header first, then instruction halfwords, high half first.
- mem_we  out  1  instruction-memory write enable, one-cycle pulse per instruction.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  write data; {hi, lo}, so opcode[31:25] comes from the first halfword.
- busy  out  1  load in progress.
- done  out  1  level; load finished, held until the next accepted start.
- err  out  1  level; header length exceeds capacity; held until the next accepted start.
- cpu_hold  out  1  keeps the pipeline stalled; 1 from reset until a successful load.

Behaviour:
- Reset (rst=0, async): state=IDLE, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_hold=1, internal count/index=0.
- Handshake: a word is accepted only on a rising edge with s_valid&s_ready. s_data is sampled only on accept. s_valid may drop or stay high freely; no word is ever consumed twice.
- States: IDLE, LEN, HI, LO, WRITE, DONE.
- IDLE: s_ready=0. On start: go to LEN; busy=1, done=0, err=0, cpu_hold=1.
- LEN: s_ready=1. On accept: remaining=s_data, index=0.
  - If s_data==0: go to DONE with err=0.
  - If s_data > DEPTH-BASE_ADDR: err=1, go to DONE; no memory write occurs.
  - Otherwise go to HI.
- HI: s_ready=1. On accept: hi_reg=s_data; go to LO.
- LO: s_ready=1. On accept, registered: mem_wdata={hi_reg,s_data}, mem_addr=BASE_ADDR+index, mem_we=1; go to WRITE.
- WRITE: s_ready=0. mem_we is high for exactly this one cycle. index++, remaining--. If the pre-decrement remaining==1, go to DONE, else go to HI.
- mem_we is 0 in every state except WRITE. mem_addr and mem_wdata hold their last values otherwise.
- DONE: s_ready=0, busy=0, done=1, cpu_hold=err (released only on success). A new start in DONE behaves as in IDLE.
- Latency and throughput:
  - First write pulse occurs 1 cycle after the LO accept.
  - Best-case throughput is 1 instruction per 3 cycles.
  - done rises the cycle after the final WRITE.
- start while busy=1 is ignored, including start coincident with an accept.
- Address arithmetic is modulo 2**ADDR_W. The capacity check guarantees no wrap during a legal load.
- Reset mid-load: all outputs return to reset values immediately. Memory contents already written are left as-is. cpu_hold=1.
- The remaining counter is 16 bits wide; header values up to 65535 are compared against capacity without truncation.

Decomposition:
- Shared package (processor-wide): INSTR_W=32, HALF_W=16, and the loader state enum (IDLE, LEN, HI, LO, WRITE, DONE).
- Single module, no sub-module. The halfword assembler is a register plus mux and does not justify its own block.

Test Plan:
- Nominal load: BASE_ADDR=0; start, then stream 2, 0x1234, 0x5678, 0x9ABC, 0xDEF0 with s_valid held high. Expect mem_we pulses writing addr0=0x12345678 and addr1=0x9ABCDEF0. done=1 and cpu_hold=0 one cycle after the second write; no other mem_we pulses.
- Backpressure and gaps: same image with s_valid toggled randomly. Expect identical writes. s_ready=0 during every WRITE cycle, and no word is consumed while s_ready=0.
- Zero length: start then header 0. Expect no mem_we, done=1, err=0, cpu_hold=0 within 2 cycles.
- Overflow: ADDR_W=4, BASE_ADDR=10; header 7 (capacity 6). Expect err=1, done=1, cpu_hold=1, and zero mem_we pulses. Header 6 with 12 halfwords loads addresses 10..15 successfully.
- Reset mid-load: assert rst=0 after the first instruction is written. Outputs go to reset values asynchronously (cpu_hold=1, busy=0). A following start plus full image completes normally from index 0.
- Spurious start: pulse start during HI and during WRITE. Expect no state change and no restart of index; the load completes as in the nominal case.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared processor-wide definitions: instruction/halfword widths and loader states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package imem_loader_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned HALF_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot-image loader: assembles 16-bit stream words into 32-bit instructions and writes imem.
// Latency: write pulse 1 cycle after the low-half accept; at best 1 instruction per 3 cycles.
// Backpressure: s_ready is low in IDLE, WRITE and DONE; words are consumed only on s_valid&s_ready.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [HALF_W-1:0]   s_data,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [INSTR_W-1:0]  mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                cpu_hold
);

  // Number of words that fit between BASE_ADDR and the top of memory; kept
  // 32 bits wide so a 16-bit header is compared without truncation.
  localparam int unsigned       CAPACITY = (32'd1 << ADDR_W) - BASE_ADDR;
  localparam logic [ADDR_W-1:0] BASE_W   = ADDR_W'(BASE_ADDR);

  loader_state_e        state_q, state_d;
  logic [HALF_W-1:0]    rem_q, rem_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [HALF_W-1:0]    hi_q, hi_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0]   wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic                 accept;

  // Status outputs are pure functions of the state and the sticky error flag.
  assign s_ready   = (state_q == ST_LEN) || (state_q == ST_HI) || (state_q == ST_LO);
  assign busy      = (state_q == ST_LEN) || (state_q == ST_HI) ||
                     (state_q == ST_LO)  || (state_q == ST_WRITE);
  assign mem_we    = (state_q == ST_WRITE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign cpu_hold  = !((state_q == ST_DONE) && !err_q);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign accept    = s_valid && s_ready;

  // Next-state logic: header check, halfword assembly and write sequencing.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // start is only honoured while not busy, which is exactly these states.
        if (start) begin
          state_d = ST_LEN;
          err_d   = 1'b0;
        end
      end
      ST_LEN: begin
        if (accept) begin
          rem_d = s_data;
          idx_d = '0;
          if (s_data == '0) begin
            state_d = ST_DONE;
          end else if (32'(s_data) > CAPACITY) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_HI;
          end
        end
      end
      ST_HI: begin
        if (accept) begin
          hi_d    = s_data;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (accept) begin
          wdata_d = {hi_q, s_data};
          addr_d  = BASE_W + idx_q;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d   = idx_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == 16'd1) ? ST_DONE : ST_HI;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset returns every output to its idle value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: default instance plus a small-memory instance for capacity limits.
// Latency: checks write timing and done/cpu_hold one cycle after the final write.
// Backpressure: drives gapped s_valid and checks no write cycle ever advertises s_ready.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        s_valid;
  logic [15:0] s_data;
  logic        sel;
  logic        rdy;

  logic        a_s_ready, a_mem_we, a_busy, a_done, a_err, a_cpu_hold;
  logic [11:0] a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic        b_s_ready, b_mem_we, b_busy, b_done, b_err, b_cpu_hold;
  logic [3:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] wa_addr[$], wa_data[$], wb_addr[$], wb_data[$];
  int acc_a = 0, acc_b = 0, we_rdy = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(12), .BASE_ADDR(0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .s_valid(s_valid), .s_ready(a_s_ready),
    .s_data(s_data), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .busy(a_busy), .done(a_done), .err(a_err), .cpu_hold(a_cpu_hold)
  );

  imem_loader #(.ADDR_W(4), .BASE_ADDR(10)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .s_valid(s_valid), .s_ready(b_s_ready),
    .s_data(s_data), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .busy(b_busy), .done(b_done), .err(b_err), .cpu_hold(b_cpu_hold)
  );

  assign rdy = sel ? b_s_ready : a_s_ready;

  // Record writes and handshakes midway through each cycle, when everything is settled.
  always @(negedge clk) begin
    if (a_mem_we) begin wa_addr.push_back(32'(a_mem_addr)); wa_data.push_back(a_mem_wdata); end
    if (b_mem_we) begin wb_addr.push_back(32'(b_mem_addr)); wb_data.push_back(b_mem_wdata); end
    if (s_valid && a_s_ready) acc_a++;
    if (s_valid && b_s_ready) acc_b++;
    if ((a_mem_we && a_s_ready) || (b_mem_we && b_s_ready)) we_rdy++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa_addr.delete(); wa_data.delete(); wb_addr.delete(); wb_data.delete();
    acc_a = 0; acc_b = 0; we_rdy = 0;
  endtask

  // Called at posedge+1; leaves start low one edge later.
  task automatic pulse_start(input bit to_b);
    if (to_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 0;
  endtask

  // Present one word until the selected instance accepts it; returns at posedge+1.
  task automatic send(input logic [15:0] d, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        s_valid = 1'b0; s_data = 16'($urandom);
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1; s_data = d;
    n = 0;
    @(negedge clk);
    while (!rdy && n < 50) begin @(negedge clk); n++; end
    check("wait_ready", 32'(rdy), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_image(input bit gaps);
    send(16'd2, gaps);
    send(16'h1234, gaps); send(16'h5678, gaps);
    send(16'h9ABC, gaps); send(16'hDEF0, gaps);
    s_valid = 1'b0;
  endtask

  // After the last LO accept: write cycle now, done on the next cycle.
  task automatic check_nominal_end(input string tag);
    check({tag, "_we_last"}, 32'(a_mem_we), 32'd1);
    check({tag, "_done_early"}, 32'(a_done), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done"}, 32'(a_done), 32'd1);
    check({tag, "_hold"}, 32'(a_cpu_hold), 32'd0);
    check({tag, "_busy"}, 32'(a_busy), 32'd0);
    check({tag, "_err"}, 32'(a_err), 32'd0);
    check({tag, "_nwr"}, 32'(wa_addr.size()), 32'd2);
    if (wa_addr.size() == 2) begin
      check({tag, "_a0"}, wa_addr[0], 32'd0);
      check({tag, "_d0"}, wa_data[0], 32'h12345678);
      check({tag, "_a1"}, wa_addr[1], 32'd1);
      check({tag, "_d1"}, wa_data[1], 32'h9ABCDEF0);
    end
  endtask

  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; s_valid = 1'b0; s_data = '0; sel = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_ready", 32'(a_s_ready), 32'd0);
    check("rst_we", 32'(a_mem_we), 32'd0);
    check("rst_addr", 32'(a_mem_addr), 32'd0);
    check("rst_wdata", a_mem_wdata, 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_hold", 32'(a_cpu_hold), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Nominal load with s_valid held high.
    clear_log();
    pulse_start(1'b0);
    check("nom_busy", 32'(a_busy), 32'd1);
    send_image(1'b0);
    check_nominal_end("nom");
    check("nom_acc", 32'(acc_a), 32'd5);

    // Same image with random gaps on s_valid.
    clear_log();
    pulse_start(1'b0);
    send_image(1'b1);
    check_nominal_end("gap");
    check("gap_acc", 32'(acc_a), 32'd5);
    check("gap_we_rdy", 32'(we_rdy), 32'd0);

    // Zero-length image.
    clear_log();
    pulse_start(1'b0);
    send(16'd0, 1'b0);
    s_valid = 1'b0;
    check("zero_done", 32'(a_done), 32'd1);
    check("zero_err", 32'(a_err), 32'd0);
    check("zero_hold", 32'(a_cpu_hold), 32'd0);
    @(posedge clk); #1;
    check("zero_nwr", 32'(wa_addr.size()), 32'd0);

    // Small memory: header 7 exceeds capacity 6.
    clear_log();
    sel = 1'b1;
    pulse_start(1'b1);
    send(16'd7, 1'b0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("ovf_done", 32'(b_done), 32'd1);
    check("ovf_err", 32'(b_err), 32'd1);
    check("ovf_hold", 32'(b_cpu_hold), 32'd1);
    check("ovf_nwr", 32'(wb_addr.size()), 32'd0);

    // Header 6 fills addresses 10..15 exactly.
    clear_log();
    pulse_start(1'b1);
    check("fit_err_clr", 32'(b_err), 32'd0);
    send(16'd6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(16'hA000 + 16'(i), 1'b0);
      send(16'h5000 + 16'(i), 1'b0);
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("fit_done", 32'(b_done), 32'd1);
    check("fit_err", 32'(b_err), 32'd0);
    check("fit_hold", 32'(b_cpu_hold), 32'd0);
    check("fit_nwr", 32'(wb_addr.size()), 32'd6);
    if (wb_addr.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("fit_a%0d", i), wb_addr[i], 32'(10 + i));
        check($sformatf("fit_d%0d", i), wb_data[i], {16'hA000 + 16'(i), 16'h5000 + 16'(i)});
      end
    end
    sel = 1'b0;

    // Reset after the first instruction is written, then reload from scratch.
    clear_log();
    pulse_start(1'b0);
    send(16'd2, 1'b0);
    send(16'h1111, 1'b0); send(16'h2222, 1'b0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_nwr", 32'(wa_addr.size()), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_busy", 32'(a_busy), 32'd0);
    check("mid_hold", 32'(a_cpu_hold), 32'd1);
    check("mid_wdata", a_mem_wdata, 32'd0);
    check("mid_ready", 32'(a_s_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    clear_log();
    pulse_start(1'b0);
    send_image(1'b0);
    check_nominal_end("rl");

    // Spurious starts during HI and during WRITE must not restart the load.
    clear_log();
    pulse_start(1'b0);
    send(16'd2, 1'b0);
    s_valid = 1'b0;
    pulse_start(1'b0);
    check("sp_busy_hi", 32'(a_busy), 32'd1);
    send(16'h1234, 1'b0); send(16'h5678, 1'b0);
    s_valid = 1'b0;
    check("sp_we", 32'(a_mem_we), 32'd1);
    pulse_start(1'b0);
    send(16'h9ABC, 1'b0); send(16'hDEF0, 1'b0);
    s_valid = 1'b0;
    check_nominal_end("sp");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
